// File: rtl/mips_hazard_ctrl_pkg.sv
// hazard_pkg: shared types for the MIPS hazard/pipeline-control unit.
//   sb_entry_t  - one scoreboard slot (an in-flight instruction, EX..WB)
//   SB_AW       - register-address width stored in the scoreboard
//   FWD_REGFILE - forward-select value meaning "take operand from regfile"
//   clog2       - elaboration-time helper for the FWD_W width check
package hazard_pkg;

  // Scoreboard address fields are stored at a fixed width; the top checks
  // that its REG_AW fits and zero-extends the ID fields on entry.
  localparam int SB_AW       = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] dest;
    logic             reg_write;
    logic             mem_read;
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } sb_entry_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// mips_hazard_ctrl_if: ID-stage/redirect inputs and stall/flush/forward
// outputs between the pipeline (master) and the hazard unit (slave).
//   id_*        - decoded fields of the instruction currently in ID
//   redirect_i  - taken branch/jump resolved in EX
//   stall_o, flush_ifid_o, bubble_idex_o, fwd_a_sel_o, fwd_b_sel_o, ex_valid_o
interface mips_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int FWD_W  = 3
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic [REG_AW-1:0] id_dest_i;
  logic              id_reg_write_i;
  logic              id_mem_read_i;
  logic              redirect_i;
  logic              stall_o;
  logic              flush_ifid_o;
  logic              bubble_idex_o;
  logic [FWD_W-1:0]  fwd_a_sel_o;
  logic [FWD_W-1:0]  fwd_b_sel_o;
  logic              ex_valid_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_dest_i, id_reg_write_i, id_mem_read_i, redirect_i,
    input  stall_o, flush_ifid_o, bubble_idex_o, fwd_a_sel_o, fwd_b_sel_o,
           ex_valid_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_dest_i, id_reg_write_i, id_mem_read_i, redirect_i,
    output stall_o, flush_ifid_o, bubble_idex_o, fwd_a_sel_o, fwd_b_sel_o,
           ex_valid_o
  );
endinterface

// File: rtl/mips_hazard_ctrl_fwd_pick.sv
// hazard_fwd_pick: combinational priority matcher for one EX operand.
//   cons_valid_i/use_i/src_i - the EX consumer and the register it reads
//   prod_wr_i/prod_dest_i    - per-stage "valid & reg_write" and destination
//   sel_o                    - nearest producing stage (1..PIPE_DEPTH-1), or 0
module hazard_fwd_pick
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int FWD_W      = 3
) (
  input  logic                              cons_valid_i,
  input  logic                              use_i,
  input  logic [SB_AW-1:0]                  src_i,
  input  logic [PIPE_DEPTH-1:0]             prod_wr_i,
  input  logic [PIPE_DEPTH-1:0][SB_AW-1:0]  prod_dest_i,
  output logic [FWD_W-1:0]                  sel_o
);

  // Stage 0 is the consumer itself; it is passed in only to keep indices aligned.
  logic unused_stage0;
  assign unused_stage0 = prod_wr_i[0] ^ (^prod_dest_i[0]);

  always_comb begin
    sel_o = FWD_W'(FWD_REGFILE);
    if (cons_valid_i && use_i && src_i != '0) begin
      // Scan oldest to newest so the nearest producer is the last to win.
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
        if (prod_wr_i[k] && prod_dest_i[k] == src_i) sel_o = FWD_W'(k);
      end
    end
  end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: scoreboard-based hazard and pipeline-control unit.
//   clk, reset (async, active-low) - plain ports
//   hz_if (slave)                  - ID fields, redirect, stall/flush/bubble,
//                                    forward selects, ex_valid
// Optional: define HAZ_PERF_CNT_EN to add saturating stall_cnt_o/flush_cnt_o.
module mips_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW           = 5,
  parameter int PIPE_DEPTH       = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int FWD_W            = 3
) (
  input  logic               clk,
  input  logic               reset,
  mips_hazard_ctrl_if.slave  hz_if
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  if (PIPE_DEPTH < 2 || PIPE_DEPTH > 6) begin : g_bad_depth
    $error("PIPE_DEPTH must be within 2..6");
  end
  if (LOAD_READY_STAGE < 1 || LOAD_READY_STAGE > PIPE_DEPTH - 1) begin : g_bad_lrs
    $error("LOAD_READY_STAGE must be within 1..PIPE_DEPTH-1");
  end
  if (FWD_W < clog2(PIPE_DEPTH) || REG_AW > SB_AW) begin : g_bad_width
    $error("FWD_W too narrow or REG_AW too wide");
  end

  sb_entry_t sb_q [PIPE_DEPTH];
  sb_entry_t sb_d [PIPE_DEPTH];
  sb_entry_t id_entry;
  logic      hz, stall, redirect;
  logic [FWD_W-1:0]                  fwd_a_sel, fwd_b_sel;
  logic [PIPE_DEPTH-1:0]             prod_wr;
  logic [PIPE_DEPTH-1:0][SB_AW-1:0]  prod_dest;
  logic      fwd_load_early;
  logic      unused_sb;

  assign redirect = hz_if.redirect_i;

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = 1'b1;
    id_entry.dest      = SB_AW'(hz_if.id_dest_i);
    id_entry.reg_write = hz_if.id_reg_write_i;
    id_entry.mem_read  = hz_if.id_mem_read_i;
    id_entry.rs        = SB_AW'(hz_if.id_rs_i);
    id_entry.rt        = SB_AW'(hz_if.id_rt_i);
    id_entry.use_rs    = hz_if.id_use_rs_i;
    id_entry.use_rt    = hz_if.id_use_rt_i;
  end

  // A load at stage k reaches k+1 when the ID instruction enters EX, so it
  // only blocks issue while k+1 is still short of LOAD_READY_STAGE.
  always_comb begin
    hz = 1'b0;
    for (int k = 0; k < LOAD_READY_STAGE - 1; k++) begin
      if (sb_q[k].valid && sb_q[k].mem_read && sb_q[k].reg_write &&
          sb_q[k].dest != '0 &&
          ((id_entry.use_rs && sb_q[k].dest == id_entry.rs) ||
           (id_entry.use_rt && sb_q[k].dest == id_entry.rt)))
        hz = 1'b1;
    end
    hz = hz & hz_if.id_valid_i;
  end

  assign stall = hz & ~redirect;

  always_comb begin
    sb_d[0] = '0;
    if (hz_if.id_valid_i && !stall && !redirect) sb_d[0] = id_entry;
    for (int k = 1; k < PIPE_DEPTH; k++) sb_d[k] = sb_q[k-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < PIPE_DEPTH; k++) sb_q[k] <= '0;
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) sb_q[k] <= sb_d[k];
    end
  end

  always_comb begin
    unused_sb = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      prod_wr[k]   = sb_q[k].valid & sb_q[k].reg_write;
      prod_dest[k] = sb_q[k].dest;
      unused_sb    = unused_sb ^ (^sb_q[k]);
    end
  end

  hazard_fwd_pick #(.PIPE_DEPTH(PIPE_DEPTH), .FWD_W(FWD_W)) u_pick_a (
    .cons_valid_i (sb_q[0].valid),
    .use_i        (sb_q[0].use_rs),
    .src_i        (sb_q[0].rs),
    .prod_wr_i    (prod_wr),
    .prod_dest_i  (prod_dest),
    .sel_o        (fwd_a_sel)
  );

  hazard_fwd_pick #(.PIPE_DEPTH(PIPE_DEPTH), .FWD_W(FWD_W)) u_pick_b (
    .cons_valid_i (sb_q[0].valid),
    .use_i        (sb_q[0].use_rt),
    .src_i        (sb_q[0].rt),
    .prod_wr_i    (prod_wr),
    .prod_dest_i  (prod_dest),
    .sel_o        (fwd_b_sel)
  );

  assign hz_if.stall_o       = stall;
  assign hz_if.flush_ifid_o  = redirect;
  assign hz_if.bubble_idex_o = stall | redirect;
  assign hz_if.fwd_a_sel_o   = fwd_a_sel;
  assign hz_if.fwd_b_sel_o   = fwd_b_sel;
  assign hz_if.ex_valid_o    = sb_q[0].valid;

  // A load whose data is not yet available must never be picked as a source.
  always_comb begin
    fwd_load_early = 1'b0;
    for (int k = 1; k < LOAD_READY_STAGE; k++) begin
      if (sb_q[k].mem_read &&
          (fwd_a_sel == FWD_W'(k) || fwd_b_sel == FWD_W'(k)))
        fwd_load_early = 1'b1;
    end
  end

  a_no_early_load_fwd: assert property (@(posedge clk) disable iff (!reset) !fwd_load_early);

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    if (redirect && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
